// File: rtl/cu_sample_packer.sv
// Frames buffered 16-bit samples as SYNC, SEQ, then MSB/LSB byte pairs on a valid/ack byte port.
// Define CU_PACK_CHKSUM_EN to append an XOR checksum byte after every frame.
module cu_sample_packer #(
  parameter int         DEPTH_LOG2 = 4,
  parameter int         FRAME_LEN  = 16,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         sample_in,
  input  logic                sample_rdy,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  input  logic                byte_ack,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic                fifo_full,
  output logic                overflow
);

  localparam int                  DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_CNT     = (DEPTH_LOG2+1)'(1);
  localparam logic [7:0]          FRAME_LEN_B = 8'(FRAME_LEN);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_SEQ  = 3'd2,
    ST_MSB  = 3'd3,
    ST_LSB  = 3'd4
`ifdef CU_PACK_CHKSUM_EN
    , ST_CHK = 3'd5
`endif
  } state_t;

  logic [15:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  state_t                state_q;
  state_t                state_d;
  logic [7:0]            byte_q;
  logic [7:0]            byte_d;
  logic                  vld_q;
  logic                  vld_d;
  logic [7:0]            seq_q;
  logic [7:0]            seq_d;
  logic [7:0]            frm_q;
  logic [7:0]            frm_d;
  logic [7:0]            frm_inc;
  logic                  ovf_q;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  ack;
  logic [15:0]           head;
  logic [15:0]           head_nxt;
`ifdef CU_PACK_CHKSUM_EN
  logic [7:0]            chk_q;
  logic [7:0]            chk_d;
`endif

  assign full       = (count_q == FULL_CNT);
  assign push       = sample_rdy && !full;
  assign ack        = vld_q && byte_ack;
  assign pop        = ack && (state_q == ST_LSB);
  assign count_d    = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  assign rd_ptr_nxt = rd_ptr_q + DEPTH_LOG2'(1);
  assign frm_inc    = frm_q + 8'd1;
  assign head       = mem_q[rd_ptr_q];
  // After popping the last stored word, the next head is the sample being written this edge.
  assign head_nxt   = (count_q == ONE_CNT) ? sample_in : mem_q[rd_ptr_nxt];

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    vld_d   = vld_q;
    seq_d   = seq_q;
    frm_d   = frm_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          vld_d = 1'b1;
          if (frm_q == 8'd0) begin
            state_d = ST_SYNC;
            byte_d  = SYNC_BYTE;
          end else begin
            state_d = ST_MSB;
            byte_d  = head[15:8];
          end
        end
      end
      ST_SYNC: begin
        if (ack) begin
          state_d = ST_SEQ;
          byte_d  = seq_q;
        end
      end
      ST_SEQ: begin
        if (ack) begin
          seq_d   = seq_q + 8'd1;
          state_d = ST_MSB;
          byte_d  = head[15:8];
        end
      end
      ST_MSB: begin
        if (ack) begin
          state_d = ST_LSB;
          byte_d  = head[7:0];
        end
      end
      ST_LSB: begin
        if (ack) begin
          if (frm_inc == FRAME_LEN_B) begin
            frm_d = 8'd0;
`ifdef CU_PACK_CHKSUM_EN
            state_d = ST_CHK;
            byte_d  = chk_q ^ byte_q;
`else
            state_d = ST_IDLE;
            vld_d   = 1'b0;
`endif
          end else begin
            frm_d = frm_inc;
            if (count_d != '0) begin
              state_d = ST_MSB;
              byte_d  = head_nxt[15:8];
            end else begin
              state_d = ST_IDLE;
              vld_d   = 1'b0;
            end
          end
        end
      end
`ifdef CU_PACK_CHKSUM_EN
      ST_CHK: begin
        if (ack) begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

`ifdef CU_PACK_CHKSUM_EN
  // Running XOR over SEQ and sample bytes, restarted whenever a new frame opens.
  always_comb begin
    chk_d = chk_q;
    if (state_q == ST_IDLE && state_d == ST_SYNC) begin
      chk_d = 8'h00;
    end else if (ack && (state_q == ST_SEQ || state_q == ST_MSB || state_q == ST_LSB)) begin
      chk_d = chk_q ^ byte_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_q <= 8'h00;
    end else begin
      chk_q <= chk_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      byte_q   <= 8'h00;
      vld_q    <= 1'b0;
      seq_q    <= 8'h00;
      frm_q    <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
      count_q <= count_d;
      state_q <= state_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      seq_q   <= seq_d;
      frm_q   <= frm_d;
      ovf_q   <= ovf_q | (sample_rdy & full);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = vld_q;
  assign fifo_count = count_q;
  assign fifo_full  = full;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cu_sample_packer.sv
// Bench for cu_sample_packer: two instances (FRAME_LEN 2 and 1) with byte scoreboards.
module tb_cu_sample_packer;

  localparam int FL_A = 2;
  localparam int FL_B = 1;
`ifdef CU_PACK_CHKSUM_EN
  localparam int CUT_BYTES = 10;
`else
  localparam int CUT_BYTES = 9;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] sin_a, sin_b;
  logic        srdy_a, srdy_b;
  logic [7:0]  bout_a, bout_b;
  logic        bvld_a, bvld_b;
  logic        back_a, back_b;
  logic [4:0]  cnt_a, cnt_b;
  logic        full_a, full_b;
  logic        ovf_a, ovf_b;

  cu_sample_packer #(.DEPTH_LOG2(4), .FRAME_LEN(FL_A), .SYNC_BYTE(8'hA5)) u_dut_a (
    .clk(clk), .reset(reset), .sample_in(sin_a), .sample_rdy(srdy_a),
    .byte_out(bout_a), .byte_valid(bvld_a), .byte_ack(back_a),
    .fifo_count(cnt_a), .fifo_full(full_a), .overflow(ovf_a)
  );

  cu_sample_packer #(.DEPTH_LOG2(4), .FRAME_LEN(FL_B), .SYNC_BYTE(8'hA5)) u_dut_b (
    .clk(clk), .reset(reset), .sample_in(sin_b), .sample_rdy(srdy_b),
    .byte_out(bout_b), .byte_valid(bvld_b), .byte_ack(back_b),
    .fifo_count(cnt_b), .fifo_full(full_b), .overflow(ovf_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] seq_a, seq_b, chk_a, chk_b;
  int         frm_a, frm_b;
  logic       hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] hold_byte_a, hold_byte_b;

  // Expected byte stream for one accepted sample.
  task automatic exp_a(input logic [15:0] s);
    if (frm_a == 0) begin
      qa.push_back(8'hA5);
      qa.push_back(seq_a);
      chk_a = seq_a;
      seq_a = seq_a + 8'd1;
    end
    qa.push_back(s[15:8]);
    qa.push_back(s[7:0]);
    chk_a = chk_a ^ s[15:8] ^ s[7:0];
    frm_a++;
    if (frm_a == FL_A) begin
      frm_a = 0;
`ifdef CU_PACK_CHKSUM_EN
      qa.push_back(chk_a);
`endif
    end
  endtask

  task automatic exp_b(input logic [15:0] s);
    if (frm_b == 0) begin
      qb.push_back(8'hA5);
      qb.push_back(seq_b);
      chk_b = seq_b;
      seq_b = seq_b + 8'd1;
    end
    qb.push_back(s[15:8]);
    qb.push_back(s[7:0]);
    chk_b = chk_b ^ s[15:8] ^ s[7:0];
    frm_b++;
    if (frm_b == FL_B) begin
      frm_b = 0;
`ifdef CU_PACK_CHKSUM_EN
      qb.push_back(chk_b);
`endif
    end
  endtask

  always @(negedge clk) begin
    if (hold_a && !reset) begin
      n_checks++;
      if (bvld_a !== 1'b1 || bout_a !== hold_byte_a)
        $display("FAIL hold_a: valid=%b byte=%h, expected valid=1 byte=%h", bvld_a, bout_a, hold_byte_a);
      else n_pass++;
    end
    if (!reset && bvld_a === 1'b1 && back_a === 1'b1) begin
      n_checks++;
      if (qa.size() == 0) $display("FAIL byte_a: got %h, expected no byte", bout_a);
      else begin
        if (bout_a !== qa[0]) $display("FAIL byte_a: got %h, expected %h", bout_a, qa[0]);
        else n_pass++;
        void'(qa.pop_front());
      end
    end
    hold_a      <= !reset && bvld_a === 1'b1 && back_a === 1'b0;
    hold_byte_a <= bout_a;
  end

  always @(negedge clk) begin
    if (hold_b && !reset) begin
      n_checks++;
      if (bvld_b !== 1'b1 || bout_b !== hold_byte_b)
        $display("FAIL hold_b: valid=%b byte=%h, expected valid=1 byte=%h", bvld_b, bout_b, hold_byte_b);
      else n_pass++;
    end
    if (!reset && bvld_b === 1'b1 && back_b === 1'b1) begin
      n_checks++;
      if (qb.size() == 0) $display("FAIL byte_b: got %h, expected no byte", bout_b);
      else begin
        if (bout_b !== qb[0]) $display("FAIL byte_b: got %h, expected %h", bout_b, qb[0]);
        else n_pass++;
        void'(qb.pop_front());
      end
    end
    hold_b      <= !reset && bvld_b === 1'b1 && back_b === 1'b0;
    hold_byte_b <= bout_b;
  end

  task automatic do_reset();
    reset = 1'b1;
    srdy_a = 1'b0; srdy_b = 1'b0; back_a = 1'b0; back_b = 1'b0;
    sin_a = 16'h0; sin_b = 16'h0;
    qa.delete(); qb.delete();
    seq_a = 8'h0; seq_b = 8'h0; chk_a = 8'h0; chk_b = 8'h0; frm_a = 0; frm_b = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic push_a(input logic [15:0] s, input bit accept);
    sin_a = s; srdy_a = 1'b1;
    if (accept) exp_a(s);
    @(posedge clk); #1;
    srdy_a = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] s);
    sin_b = s; srdy_b = 1'b1;
    exp_b(s);
    @(posedge clk); #1;
    srdy_b = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bout_a, bvld_a, cnt_a, full_a, ovf_a} !== 16'h0)
      $display("FAIL reset_a: outputs=%h, expected 0000", {bout_a, bvld_a, cnt_a, full_a, ovf_a});
    else n_pass++;
    n_checks++;
    if ({bout_b, bvld_b, cnt_b, full_b, ovf_b} !== 16'h0)
      $display("FAIL reset_b: outputs=%h, expected 0000", {bout_b, bvld_b, cnt_b, full_b, ovf_b});
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    back_a = 1'b1;
    push_a(16'h1234, 1'b1);
    n_checks++;
    if (bvld_a !== 1'b0 || cnt_a !== 5'd1)
      $display("FAIL single_lat1: valid=%b count=%0d, expected valid=0 count=1", bvld_a, cnt_a);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bvld_a !== 1'b1 || bout_a !== 8'hA5)
      $display("FAIL single_lat2: valid=%b byte=%h, expected valid=1 byte=a5", bvld_a, bout_a);
    else n_pass++;
    for (int i = 0; i < 100 && qa.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (qa.size() != 0) $display("FAIL single_drain: %0d bytes left, expected 0", qa.size());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bvld_a !== 1'b0 || cnt_a !== 5'd0)
      $display("FAIL single_idle: valid=%b count=%0d, expected valid=0 count=0", bvld_a, cnt_a);
    else n_pass++;
  endtask

  task automatic test_two_frames();
    do_reset();
    back_a = 1'b1;
    push_a(16'd10, 1'b1);
    push_a(16'd9, 1'b1);
    push_a(16'd8, 1'b1);
    push_a(16'd7, 1'b1);
    for (int i = 0; i < 200 && qa.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (qa.size() != 0) $display("FAIL frames_drain: %0d bytes left, expected 0", qa.size());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bvld_a !== 1'b0 || cnt_a !== 5'd0)
      $display("FAIL frames_idle: valid=%b count=%0d, expected valid=0 count=0", bvld_a, cnt_a);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 16; i++) push_a(16'h0100 + 16'(i), 1'b1);
    n_checks++;
    if (full_a !== 1'b1 || cnt_a !== 5'd16 || ovf_a !== 1'b0)
      $display("FAIL ovf_full: full=%b count=%0d ovf=%b, expected 1/16/0", full_a, cnt_a, ovf_a);
    else n_pass++;
    push_a(16'hBEEF, 1'b0);
    n_checks++;
    if (ovf_a !== 1'b1 || cnt_a !== 5'd16)
      $display("FAIL ovf_drop: ovf=%b count=%0d, expected 1/16", ovf_a, cnt_a);
    else n_pass++;
    back_a = 1'b1;
    for (int i = 0; i < 1000 && qa.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (qa.size() != 0) $display("FAIL ovf_drain: %0d bytes left, expected 0", qa.size());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ovf_a !== 1'b1 || cnt_a !== 5'd0)
      $display("FAIL ovf_sticky: ovf=%b count=%0d, expected 1/0", ovf_a, cnt_a);
    else n_pass++;
  endtask

  task automatic test_full_pop_drop();
    do_reset();
    for (int i = 0; i < 16; i++) push_a(16'hC000 + 16'(i * 3), 1'b1);
    // SYNC, SEQ and MSB accepted on three edges; the fourth ack pops in LSB.
    back_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sin_a = 16'hDEAD; srdy_a = 1'b1;
    @(posedge clk); #1;
    srdy_a = 1'b0; back_a = 1'b0;
    n_checks++;
    if (ovf_a !== 1'b1 || cnt_a !== 5'd15 || full_a !== 1'b0)
      $display("FAIL popdrop: ovf=%b count=%0d full=%b, expected 1/15/0", ovf_a, cnt_a, full_a);
    else n_pass++;
    back_a = 1'b1;
    for (int i = 0; i < 1000 && qa.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (qa.size() != 0) $display("FAIL popdrop_drain: %0d bytes left, expected 0", qa.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    do_reset();
    for (int i = 1; i <= 4; i++) push_a(16'h1100 * 16'(i) + 16'(i), 1'b1);
    back_a = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < CUT_BYTES; i++) begin
      @(negedge clk);
      if (bvld_a === 1'b1) n++;
    end
    @(posedge clk); #1;
    back_a = 1'b0;
    reset = 1'b1;
    n_checks++;
    if (n != CUT_BYTES) $display("FAIL midrst_count: %0d bytes seen, expected %0d", n, CUT_BYTES);
    else n_pass++;
    qa.delete(); seq_a = 8'h0; chk_a = 8'h0; frm_a = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({bout_a, bvld_a, cnt_a, full_a, ovf_a} !== 16'h0)
      $display("FAIL midrst_zero: outputs=%h, expected 0000", {bout_a, bvld_a, cnt_a, full_a, ovf_a});
    else n_pass++;
    back_a = 1'b1;
    push_a(16'h55AA, 1'b1);
    for (int i = 0; i < 100 && qa.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (qa.size() != 0) $display("FAIL midrst_drain: %0d bytes left, expected 0", qa.size());
    else n_pass++;
  endtask

  task automatic test_seq_wrap();
    bit done;
    int guard;
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 257; k++) begin
          guard = 0;
          while (cnt_b >= 5'd8 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
          end
          push_b({8'(k), 8'(k ^ 'h5A)});
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 20000 && !(done && qb.size() == 0); c++) begin
          back_b = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        back_b = 1'b0;
      end
    join
    n_checks++;
    if (qb.size() != 0) $display("FAIL wrap_drain: %0d bytes left, expected 0", qb.size());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ovf_b !== 1'b0 || bvld_b !== 1'b0 || cnt_b !== 5'd0)
      $display("FAIL wrap_end: ovf=%b valid=%b count=%0d, expected 0/0/0", ovf_b, bvld_b, cnt_b);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    srdy_a = 1'b0; srdy_b = 1'b0; back_a = 1'b0; back_b = 1'b0;
    sin_a = 16'h0; sin_b = 16'h0;
    test_reset();
    test_single();
    test_two_frames();
    test_overflow();
    test_full_pop_drop();
    test_reset_mid_frame();
    test_seq_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
